dpc_bp_list_flagger: RTL and testbench
======================================

Name: dpc_bp_list_flagger

Overview:
Upstream stage of the DPC corrector. Flags known (static) bad pixels from a programmable, raster-sorted coordinate list.
Passes the pixel AXI-Stream through with 1-cycle latency and emits an aligned k-stream whose MSB is the bad-pixel flag, which is the format the corrector consumes.
The list is written by the host through a simple write port and takes effect from the next frame.

Parameters:
WIDTH, 16, pixel data width
K_WIDTH, 16, k-stream width; MSB = bad flag, lower bits = matched list index
CNT_WIDTH, 10, x/y coordinate counter width
FRAME_WIDTH, 640, pixels per line
FRAME_HEIGHT, 512, lines per frame
MAX_BP, 256, list depth (entries)
ADDR_W, 8, list address width, clog2(MAX_BP)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  WIDTH  input pixel
s_axis_tuser  in  1  SOF
s_axis_tlast  in  1  EOL
m_axis_tvalid  out  1  output pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  WIDTH  output pixel (unmodified)
m_axis_tuser  out  1  SOF
m_axis_tlast  out  1  EOL
k_axis_tvalid  out  1  equals m_axis_tvalid
k_axis_tdata  out  K_WIDTH  {flag, index}
cfg_we  in  1  list write strobe
cfg_addr  in  ADDR_W  list entry address
cfg_x  in  CNT_WIDTH  entry column
cfg_y  in  CNT_WIDTH  entry row
cfg_count  in  ADDR_W+1  number of valid entries (0..MAX_BP)
enable  in  1  flagging enable
sof_err  out  1  sticky: SOF seen mid-frame
order_err  out  1  sticky: list entry skipped (not ascending or out of frame)
bp_hit_count  out  ADDR_W+1  hits in last completed frame (see optional feature)

Behaviour:
- Reset: all outputs 0, state PREFETCH, x=y=0, ptr=0, sticky errors cleared.
- List storage:
  - MAX_BP x (2*CNT_WIDTH) RAM with synchronous read; cfg_we writes {cfg_y, cfg_x} at cfg_addr.
  - Entries must be raster-ascending (y major, x minor).
  - cfg_count is latched on entry to PREFETCH. Writes during a frame are only guaranteed to apply from the next PREFETCH.
- States: PREFETCH (3 cycles: issue reads of entries 0 and 1, load cur/nxt registers) -> RUN.
  - In PREFETCH, s_axis_tready=0.
- Handshake:
  - In RUN, s_axis_tready = (m_axis_tready | ~m_axis_tvalid) & ~resync.
  - Output register loads on an accepted beat. m_axis_tvalid clears when m_axis_tready=1 and no new beat is accepted.
  - Latency is exactly 1 cycle per accepted beat. Stalls hold all outputs stable.
- Match:
  - Conditions: ptr < cnt_latched AND cur == (y,x) of the accepted beat.
  - On a match: flag = enable, index = ptr (zero-extended/truncated to K_WIDTH-1), ptr++, cur<=nxt, nxt<=RAM[ptr+2].
  - Consecutive matches on back-to-back beats must be supported.
  - Non-match: k_axis_tdata = 0.
  - enable=0 still advances ptr; only the flag is forced to 0.
- Skip: if ptr < cnt_latched and cur < (y,x) in raster order, set order_err, advance ptr by one (one skip per beat), and emit no flag for that entry.
- Coordinates:
  - tlast beat: x<=0, y++.
  - Other beat: x++.
  - tlast with y==FRAME_HEIGHT-1 is end of frame: after the beat is accepted, y<=0, ptr<=0, go to PREFETCH.
  - x wraps naturally; tlast governs line length.
- Resync: in RUN, a valid beat with tuser=1 while (x,y)!=(0,0) sets resync.
  - tready is held 0, sof_err is set, and the block goes to PREFETCH with x=y=0.
  - The SOF beat is then accepted as pixel (0,0).
- A frame with cfg_count=0 never flags.

Optional Feature:
DPC_STATS_EN:
- Defined: a per-frame hit counter increments on each flagged beat (saturating at MAX_BP). It is copied to bp_hit_count at end of frame, then cleared.
- Undefined: bp_hit_count tied 0 and no counter logic.

Test Plan:
- FRAME_WIDTH=8, FRAME_HEIGHT=4; list {(2,1),(3,1),(7,3)}, count=3; continuous stream with m_axis_tready=1 -> flag=1 with index 0, 1, 2 exactly at beats 10, 11, 31, one cycle after acceptance; all other k=0; pixels unchanged.
- Same list with m_axis_tready toggling every cycle -> identical beat and flag sequence; outputs stable during stalls; no beat lost or duplicated.
- enable=0 for frame 1, enable=1 for frame 2 -> frame 1 has no flags; frame 2 flags as in the first test; bp_hit_count=0 then 3 (DPC_STATS_EN).
- List {(5,0),(1,0)} -> (5,0) flagged; (1,0) never flagged; order_err=1 after row 1 starts.
- SOF injected at (4,2) -> tready low for 3+ cycles; sof_err=1; SOF beat is output as (0,0); entry (0,0) is flagged if present.
- Reset asserted mid-frame -> all outputs 0 within 1 cycle; after release, first SOF frame flags correctly.

Source files
------------

// File: rtl/dpc_bp_list_flagger.sv
// dpc_bp_list_flagger: flags static bad pixels from a raster-sorted coordinate list
//
// Passes the pixel AXI-Stream through a single output register (1-cycle latency)
// and emits an aligned k-stream {flag, list index} for the downstream corrector.
// The host loads the list through cfg_we/cfg_addr/cfg_x/cfg_y. cfg_count is
// captured at the start of every frame, so list updates apply from the next frame.
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   s_axis_*                   input pixel stream (tuser = SOF, tlast = EOL)
//   m_axis_*                   output pixel stream, data unmodified
//   k_axis_tvalid/k_axis_tdata aligned flag stream, MSB = bad flag, LSBs = index
//   cfg_we/cfg_addr/cfg_x/cfg_y list write port; cfg_count = valid entries
//   enable                     flag enable (list walking continues when low)
//   sof_err                    sticky: SOF arrived mid-frame
//   order_err                  sticky: list entry skipped (unsorted or out of frame)
//   bp_hit_count               flagged beats in last completed frame
//
// Build option: define DPC_STATS_EN to include the per-frame hit counter;
// without it bp_hit_count is tied to zero.
module dpc_bp_list_flagger #(
    parameter int WIDTH        = 16,
    parameter int K_WIDTH      = 16,
    parameter int CNT_WIDTH    = 10,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int MAX_BP       = 256,
    parameter int ADDR_W       = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 k_axis_tvalid,
    output logic [K_WIDTH-1:0]   k_axis_tdata,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [CNT_WIDTH-1:0] cfg_x,
    input  logic [CNT_WIDTH-1:0] cfg_y,
    input  logic [ADDR_W:0]      cfg_count,
    input  logic                 enable,
    output logic                 sof_err,
    output logic                 order_err,
    output logic [ADDR_W:0]      bp_hit_count
);

    localparam int PW = 2 * CNT_WIDTH;
    localparam logic [0:0] ST_PREFETCH = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [CNT_WIDTH:0]   X_END  = (CNT_WIDTH + 1)'(FRAME_WIDTH);
    localparam logic [CNT_WIDTH:0]   Y_END  = (CNT_WIDTH + 1)'(FRAME_HEIGHT);

    // list RAM, entries stored as {y, x} so a plain compare is raster order
    logic [PW-1:0]     mem [MAX_BP];
    logic [PW-1:0]     rd_data_q;
    logic [ADDR_W-1:0] rd_addr;

    logic [0:0]           state_q, state_d;
    logic [1:0]           pf_q, pf_d;
    logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_W:0]      ptr_q, ptr_d, cnt_q, cnt_d;
    logic [PW-1:0]        cur_q, cur_d, nxt_q, nxt_d;
    logic                 m_valid_q, m_valid_d;
    logic [WIDTH-1:0]     m_data_q, m_data_d;
    logic                 m_user_q, m_user_d, m_last_q, m_last_d;
    logic [K_WIDTH-1:0]   k_q, k_d;
    logic                 sof_err_q, sof_err_d, order_err_q, order_err_d;

    logic                 st_run, in_list, hit, out_frame, skip, resync;
    logic                 s_ready, accept, eof, adv, pf_last;
    logic [PW-1:0]        pos;
    logic [K_WIDTH-2:0]   idx;

    assign st_run    = state_q == ST_RUN;
    assign pf_last   = ~st_run & (pf_q == 2'd2);
    assign pos       = {y_q, x_q};
    assign in_list   = ptr_q < cnt_q;
    assign hit       = in_list & (cur_q == pos);
    // an entry outside the frame can never match, so drop it immediately
    assign out_frame = ({1'b0, cur_q[CNT_WIDTH-1:0]} >= X_END) |
                       ({1'b0, cur_q[PW-1:CNT_WIDTH]} >= Y_END);
    assign skip      = in_list & ~hit & ((cur_q < pos) | out_frame);
    // ready depends on valid here so the misplaced SOF beat is refused outright
    assign resync    = st_run & s_axis_tvalid & s_axis_tuser & (pos != '0);
    assign s_ready   = st_run & (m_axis_tready | ~m_valid_q) & ~resync;
    assign accept    = s_axis_tvalid & s_ready;
    assign eof       = accept & s_axis_tlast & (y_q == Y_LAST);
    assign adv       = accept & (hit | skip);
    assign idx       = (K_WIDTH - 1)'(ptr_q);

    // In RUN the read address follows ptr_d so rd_data_q always holds
    // RAM[ptr_q + 2], ready to refill nxt on back-to-back advances.
    // In PREFETCH pf_q walks addresses 0, 1, 2.
    assign rd_addr = st_run ? ptr_d[ADDR_W-1:0] + ADDR_W'(2) : ADDR_W'(pf_q);

    always_ff @(posedge aclk) begin
        if (cfg_we) mem[cfg_addr] <= {cfg_y, cfg_x};
        rd_data_q <= mem[rd_addr];
    end

    always_comb begin
        state_d     = (eof | resync) ? ST_PREFETCH : pf_last ? ST_RUN : state_q;
        pf_d        = st_run ? 2'd0 : pf_q + 2'd1;
        cnt_d       = (~st_run & (pf_q == 2'd0)) ? cfg_count : cnt_q;
        cur_d       = (~st_run & (pf_q == 2'd1)) ? rd_data_q : adv ? nxt_q : cur_q;
        nxt_d       = (pf_last | adv) ? rd_data_q : nxt_q;
        ptr_d       = (eof | resync) ? '0 : adv ? ptr_q + 1'b1 : ptr_q;
        x_d         = resync ? '0 : accept ? (s_axis_tlast ? '0 : x_q + 1'b1) : x_q;
        y_d         = (resync | eof) ? '0 : (accept & s_axis_tlast) ? y_q + 1'b1 : y_q;
        m_valid_d   = accept | (m_valid_q & ~m_axis_tready);
        m_data_d    = accept ? s_axis_tdata : m_data_q;
        m_user_d    = accept ? s_axis_tuser : m_user_q;
        m_last_d    = accept ? s_axis_tlast : m_last_q;
        k_d         = accept ? (hit ? {enable, idx} : '0) : k_q;
        sof_err_d   = sof_err_q | resync;
        order_err_d = order_err_q | (accept & skip);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_PREFETCH;
            pf_q        <= '0;
            cnt_q       <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            ptr_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_user_q    <= 1'b0;
            m_last_q    <= 1'b0;
            k_q         <= '0;
            sof_err_q   <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pf_q        <= pf_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            ptr_q       <= ptr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_user_q    <= m_user_d;
            m_last_q    <= m_last_d;
            k_q         <= k_d;
            sof_err_q   <= sof_err_d;
            order_err_q <= order_err_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign k_axis_tvalid = m_valid_q;
    assign k_axis_tdata  = k_q;
    assign sof_err       = sof_err_q;
    assign order_err     = order_err_q;

`ifdef DPC_STATS_EN
    localparam logic [ADDR_W:0] BP_MAX = (ADDR_W + 1)'(MAX_BP);

    logic [ADDR_W:0] hits_q, hits_d, hits_inc, bp_cnt_q, bp_cnt_d;

    // hits_inc includes the current beat so a hit on the last pixel is counted
    assign hits_inc = (accept & hit & enable & (hits_q != BP_MAX)) ? hits_q + 1'b1 : hits_q;

    always_comb begin
        hits_d   = (eof | resync) ? '0 : hits_inc;
        bp_cnt_d = eof ? hits_inc : bp_cnt_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hits_q   <= '0;
            bp_cnt_q <= '0;
        end else begin
            hits_q   <= hits_d;
            bp_cnt_q <= bp_cnt_d;
        end
    end

    assign bp_hit_count = bp_cnt_q;
`else
    assign bp_hit_count = '0;
`endif

endmodule

// File: tb/tb_dpc_bp_list_flagger.sv
// tb_dpc_bp_list_flagger: directed scoreboard bench for dpc_bp_list_flagger
module tb_dpc_bp_list_flagger;

    localparam int W  = 16;
    localparam int KW = 16;
    localparam int CW = 10;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int MB = 256;
    localparam int AW = 8;
    localparam int NB = FW * FH;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          k_axis_tvalid;
    logic [KW-1:0] k_axis_tdata;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_x = '0;
    logic [CW-1:0] cfg_y = '0;
    logic [AW:0]   cfg_count = '0;
    logic          enable = 1'b1;
    logic          sof_err;
    logic          order_err;
    logic [AW:0]   bp_hit_count;

    dpc_bp_list_flagger #(
        .WIDTH(W), .K_WIDTH(KW), .CNT_WIDTH(CW), .FRAME_WIDTH(FW),
        .FRAME_HEIGHT(FH), .MAX_BP(MB), .ADDR_W(AW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .k_axis_tvalid(k_axis_tvalid), .k_axis_tdata(k_axis_tdata),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_count(cfg_count), .enable(enable),
        .sof_err(sof_err), .order_err(order_err), .bp_hit_count(bp_hit_count)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic          u;
        logic          l;
        logic [KW-1:0] k;
        int            cyc;
    } exp_t;

    typedef struct {
        int x;
        int y;
        int i;
    } ent_t;

    exp_t sb[$];
    ent_t lst[$];
    ent_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   flags = 0;
    int   nout = 0;
    bit   chk_lat = 1'b1;
    bit   tog = 1'b0;

    initial forever #5 aclk = ~aclk;
    initial forever begin
        @(posedge aclk);
        cyc++;
    end
    initial forever begin
        @(posedge aclk);
        #1;
        if (tog) m_axis_tready = ~m_axis_tready;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [KW-1:0] exp_k(input int x, input int y);
        foreach (tbl[j])
            if (tbl[j].x == x && tbl[j].y == y) return {enable, (KW - 1)'(tbl[j].i)};
        return '0;
    endfunction

    task automatic add_both(input int x, input int y, input int i);
        lst.push_back('{x, y, i});
        tbl.push_back('{x, y, i});
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        sb.delete();
        #1;
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_k_valid", k_axis_tvalid, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_m_data", m_axis_tdata, 0);
        chk("rst_m_user", m_axis_tuser, 0);
        chk("rst_m_last", m_axis_tlast, 0);
        chk("rst_k_data", k_axis_tdata, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_order_err", order_err, 0);
        chk("rst_hit_count", bp_hit_count, 0);
        foreach (lst[j]) begin
            @(posedge aclk);
            #1;
            cfg_we = 1'b1;
            cfg_addr = AW'(j);
            cfg_x = CW'(lst[j].x);
            cfg_y = CW'(lst[j].y);
        end
        @(posedge aclk);
        #1;
        cfg_we = 1'b0;
        cfg_count = (AW + 1)'(lst.size());
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic send_beat(input int x, input int y, input bit u, input bit l, output int waits);
        s_axis_tdata = W'($urandom);
        s_axis_tuser = u;
        s_axis_tlast = l;
        s_axis_tvalid = 1'b1;
        waits = 0;
        @(negedge aclk);
        while (!s_axis_tready) begin
            waits++;
            if (waits > 500) begin
                errors++;
                $display("FAIL accept_timeout: beat (%0d,%0d) not accepted within 500 cycles", x, y);
                $fatal(1, "input handshake bound expired");
            end
            @(negedge aclk);
        end
        sb.push_back('{s_axis_tdata, u, l, exp_k(x, y), cyc + 1});
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_range(input int b0, input int b1);
        int w;
        for (int b = b0; b < b1; b++)
            send_beat(b % FW, b / FW, b == 0, (b % FW) == FW - 1, w);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && t < 200) begin
            @(posedge aclk);
            #2;
            t++;
        end
        chk("drain_done", t < 200, 1);
    endtask

    initial begin
        exp_t e;
        logic stall = 1'b0;
        logic [63:0] held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) stall = 1'b0;
            else begin
                if (stall)
                    chk("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, k_axis_tdata}, held);
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("pixel", m_axis_tdata, e.d);
                        chk("tuser", m_axis_tuser, e.u);
                        chk("tlast", m_axis_tlast, e.l);
                        chk("k_data", k_axis_tdata, e.k);
                        chk("k_valid", k_axis_tvalid, 1);
                        if (chk_lat) chk("latency", cyc, e.cyc);
                        flags += int'(k_axis_tdata[KW-1]);
                        nout++;
                    end
                end
                stall = m_axis_tvalid && !m_axis_tready;
                held = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, k_axis_tdata};
            end
        end
    end

    initial begin
        int w;
        repeat (2) @(posedge aclk);
        #1;

        // sorted list, continuous stream
        add_both(2, 1, 0);
        add_both(3, 1, 1);
        add_both(7, 3, 2);
        do_reset();
        flags = 0;
        nout = 0;
        send_range(0, NB);
        drain();
        chk("t1_flags", flags, 3);
        chk("t1_beats", nout, NB);

        // same list with downstream backpressure every other cycle
        chk_lat = 1'b0;
        tog = 1'b1;
        flags = 0;
        nout = 0;
        send_range(0, NB);
        drain();
        tog = 1'b0;
        m_axis_tready = 1'b1;
        chk("t2_flags", flags, 3);
        chk("t2_beats", nout, NB);
        chk_lat = 1'b1;

        // enable low then high
        enable = 1'b0;
        flags = 0;
        send_range(0, NB);
        drain();
        chk("t3_off_flags", flags, 0);
        chk("t3_off_hits", bp_hit_count, 0);
        enable = 1'b1;
        flags = 0;
        send_range(0, NB);
        drain();
        chk("t3_on_flags", flags, 3);
`ifdef DPC_STATS_EN
        chk("t3_on_hits", bp_hit_count, 3);
`else
        chk("t3_on_hits", bp_hit_count, 0);
`endif

        // unsorted list: second entry is skipped
        lst.delete();
        tbl.delete();
        lst.push_back('{5, 0, 0});
        lst.push_back('{1, 0, 1});
        tbl.push_back('{5, 0, 0});
        do_reset();
        flags = 0;
        send_range(0, 6);
        chk("t4_order_before", order_err, 0);
        send_range(6, FW + 1);
        chk("t4_order_after", order_err, 1);
        send_range(FW + 1, NB);
        drain();
        chk("t4_flags", flags, 1);

        // SOF injected at (4,2)
        lst.delete();
        tbl.delete();
        add_both(0, 0, 0);
        add_both(2, 1, 1);
        add_both(3, 1, 2);
        add_both(7, 3, 3);
        do_reset();
        flags = 0;
        send_range(0, 2 * FW + 4);
        chk("t5_sof_err_before", sof_err, 0);
        send_beat(0, 0, 1'b1, 1'b0, w);
        chk("t5_stall_ge3", w >= 3, 1);
        chk("t5_sof_err_after", sof_err, 1);
        send_range(1, NB);
        drain();
        chk("t5_flags", flags, 7);

        // reset in the middle of a frame, then a clean frame
        send_range(0, FW + 4);
        do_reset();
        flags = 0;
        nout = 0;
        send_range(0, NB);
        drain();
        chk("t6_flags", flags, 4);
        chk("t6_beats", nout, NB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
